ram_1w_nrs_clr: RTL

RAM_1W_NRS_CLR -- requirements
Module: ram_1w_nrs_clr

---
 rtl/ram_1w_nrs_clr.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ram_1w_nrs_clr.sv
// One-write / N-read RAM with a self-timed zeroing sweep after reset or on clear.
// Read latency 1+OUT_REG; no backpressure: all ports accept every cycle unless busy.
module ram_1w_nrs_clr #(
    parameter int NUM_RD_PORTS = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = 4,
    parameter int MASK_ENABLE  = 1,
    parameter int RUW_MODE     = 0,
    parameter int OUT_REG      = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clear,
    output logic                               busy,
    input  logic                               wr_en,
    input  logic [MASK_WIDTH-1:0]              wr_mask,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [NUM_RD_PORTS-1:0]            rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_valid
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_W = DATA_WIDTH / MASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    access_en;
    logic                    wr_act;
    logic [DATA_WIDTH-1:0]   wr_bit_mask;
    logic [DATA_WIDTH-1:0]   wr_merged;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear) begin
                    sweep_d = '0;
                end else if (sweep_q == SWEEP_LAST) begin
                    state_d = ST_READY;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    assign busy = (state_q == ST_CLEAR);

    // A clear request also blocks user traffic in its own cycle, so nothing
    // issued alongside it can leak out after the sweep starts.
    assign access_en = (state_q == ST_READY) && !clear;
    assign wr_act    = access_en && wr_en;

    always_comb begin
        wr_bit_mask = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            wr_bit_mask[i*LANE_W +: LANE_W] = {LANE_W{(MASK_ENABLE == 0) || wr_mask[i]}};
        end
    end

    assign wr_merged = (mem[wr_addr] & ~wr_bit_mask) | (wr_data & wr_bit_mask);

    // Array has no reset: zeroing is the sweep's job.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[sweep_q] <= '0;
        end else if (wr_act) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] port_addr;
        logic [DATA_WIDTH-1:0] rd_word;
        logic                  rd_act;
        logic [DATA_WIDTH-1:0] s1_dat_q;
        logic                  s1_vld_q;

        assign port_addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_act    = access_en && rd_en[k];

        always_comb begin
            rd_word = mem[port_addr];
            if ((RUW_MODE != 0) && wr_act && (wr_addr == port_addr)) begin
                rd_word = wr_merged;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_dat_q <= '0;
                s1_vld_q <= 1'b0;
            end else begin
                s1_vld_q <= rd_act;
                if (rd_act) begin
                    s1_dat_q <= rd_word;
                end
            end
        end

        if (OUT_REG != 0) begin : g_out
            logic [DATA_WIDTH-1:0] out_dat_q;
            logic                  out_vld_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    out_dat_q <= '0;
                    out_vld_q <= 1'b0;
                end else begin
                    out_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        out_dat_q <= s1_dat_q;
                    end
                end
            end

            assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = out_dat_q;
            assign rd_valid[k]                         = out_vld_q;
        end else begin : g_direct
            assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = s1_dat_q;
            assign rd_valid[k]                         = s1_vld_q;
        end
    end

endmodule
